spi_sram_seq: RTL and testbench

SPI_SRAM_SEQ -- requirements
Module: spi_sram_seq

---
 rtl/spi_sram_pkg.sv | 24 ++
 rtl/spi_shift_reg.sv | 39 +++
 rtl/spi_sram_seq.sv | 211 +++++++++++++++++++++
 tb/tb_spi_sram_seq.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sram_pkg.sv
// Shared state encoding, opcodes and a sizing helper for the SPI-to-SRAM sequencer.
package spi_sram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INSTR,
    ADDR,
    READ,
    WRITE,
    IGNORE
  } state_t;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load, MSB-first shift register used for both the receive and transmit paths.
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q,
  output logic         sout
);

  logic [W-1:0] q_reg;
  logic [W-1:0] shifted;

  generate
    if (W == 1) begin : g_one
      assign shifted = sin;
    end else begin : g_multi
      assign shifted = {q_reg[W-2:0], sin};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= din;
    end else if (shift) begin
      q_reg <= shifted;
    end
  end

  assign q    = q_reg;
  assign sout = q_reg[W-1];

endmodule

// File: rtl/spi_sram_seq.sv
// SPI slave that sequences SRAM reads/writes. The edge that first sees ss low only
// selects the device; the opcode's MSB is sampled on the following edge.
module spi_sram_seq
  import spi_sram_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int BURST_EN = 1
) (
  input  logic              SCK,
  input  logic              rst_n,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              we,
  output logic              re,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy
);

  localparam int RXW   = max3(8, ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(RXW + 1);
  // Prefetch point: re two bits before the end of a word lands rdata on the last bit.
  localparam int PF    = (DATA_W >= 2) ? DATA_W - 2 : 0;

  localparam logic [CNT_W-1:0] C_OP_LAST   = CNT_W'(7);
  localparam logic [CNT_W-1:0] C_ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] C_DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] C_PF        = CNT_W'(PF);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
  localparam logic [ADDR_W-1:0] A_ONE      = ADDR_W'(1);

  state_t state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              rd_op_reg, rd_op_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              we_reg, we_next;
  logic              re_reg, re_next;
  logic              rv_reg, rv_next;
  logic              wvld_reg, wvld_next;

  logic              rx_load, rx_shift, rx_sout;
  logic [RXW-1:0]    rx_q, rx_word;
  logic              tx_load, tx_fill, tx_shift, tx_sout;
  logic [DATA_W-1:0] tx_q, tx_din;
  logic              unused_bits;

  spi_shift_reg #(.W(RXW)) u_rx (
    .clk   (SCK),
    .rst_n (rst_n),
    .load  (rx_load),
    .din   ({RXW{1'b0}}),
    .shift (rx_shift),
    .sin   (mosi),
    .q     (rx_q),
    .sout  (rx_sout)
  );

  spi_shift_reg #(.W(DATA_W)) u_tx (
    .clk   (SCK),
    .rst_n (rst_n),
    .load  (tx_load),
    .din   (tx_din),
    .shift (tx_shift),
    .sin   (1'b0),
    .q     (tx_q),
    .sout  (tx_sout)
  );

  // Includes the bit being sampled on this edge, so decodes need no extra cycle.
  assign rx_word     = {rx_q[RXW-2:0], mosi};
  assign rx_load     = (state_next == IDLE);
  assign tx_load     = (state_next != READ) || tx_fill;
  assign tx_din      = (state_next == READ) ? rdata : '0;
  assign rv_next     = re_reg && !ss;
  assign unused_bits = ^{rx_sout, rx_q[RXW-1], tx_q};

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rd_op_next = rd_op_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    we_next    = 1'b0;
    re_next    = 1'b0;
    wvld_next  = wvld_reg;
    rx_shift   = 1'b0;
    tx_shift   = 1'b0;
    tx_fill    = 1'b0;

    if (we_reg) addr_next = addr_reg + A_ONE;

    case (state_reg)
      IDLE: begin
        if (!ss) state_next = INSTR;
      end
      INSTR: begin
        rx_shift = 1'b1;
        if (cnt_reg == C_OP_LAST) begin
          if (rx_word[7:0] == OP_READ) begin
            rd_op_next = 1'b1;
            state_next = ADDR;
          end else if (rx_word[7:0] == OP_WRITE) begin
            rd_op_next = 1'b0;
            state_next = ADDR;
          end else begin
            state_next = IGNORE;
          end
        end else begin
          cnt_next = cnt_reg + C_ONE;
        end
      end
      ADDR: begin
        rx_shift = 1'b1;
        if (cnt_reg == C_ADDR_LAST) begin
          addr_next  = rx_word[ADDR_W-1:0];
          state_next = rd_op_reg ? READ : WRITE;
          re_next    = rd_op_reg;
        end else begin
          cnt_next = cnt_reg + C_ONE;
        end
      end
      READ: begin
        if (rv_reg) begin
          tx_fill   = 1'b1;
          wvld_next = 1'b1;
          cnt_next  = '0;
          if (BURST_EN != 0 && PF == 0) begin
            re_next   = 1'b1;
            addr_next = addr_reg + A_ONE;
          end
        end else if (wvld_reg) begin
          tx_shift = 1'b1;
          if (BURST_EN == 0 && cnt_reg == C_DATA_LAST) begin
            state_next = IGNORE;
          end else begin
            cnt_next = cnt_reg + C_ONE;
            if (BURST_EN != 0 && (cnt_reg + C_ONE) == C_PF) begin
              re_next   = 1'b1;
              addr_next = addr_reg + A_ONE;
            end
          end
        end
      end
      WRITE: begin
        rx_shift = 1'b1;
        // Single-word mode leaves only after the we cycle so IGNORE never carries a strobe.
        if (we_reg && BURST_EN == 0) begin
          state_next = IGNORE;
        end else if (cnt_reg == C_DATA_LAST) begin
          wdata_next = rx_word[DATA_W-1:0];
          we_next    = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + C_ONE;
        end
      end
      IGNORE: begin
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (ss) begin
      state_next = IDLE;
      cnt_next   = '0;
      we_next    = 1'b0;
      re_next    = 1'b0;
      wdata_next = wdata_reg;
      addr_next  = we_reg ? addr_reg + A_ONE : addr_reg;
    end
    if (state_next != state_reg) cnt_next = '0;
    if (state_next != READ) wvld_next = 1'b0;
  end

  always_ff @(posedge SCK or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rd_op_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
      re_reg    <= 1'b0;
      rv_reg    <= 1'b0;
      wvld_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rd_op_reg <= rd_op_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      we_reg    <= we_next;
      re_reg    <= re_next;
      rv_reg    <= rv_next;
      wvld_reg  <= wvld_next;
    end
  end

  assign miso  = tx_sout;
  assign addr  = addr_reg;
  assign wdata = wdata_reg;
  assign we    = we_reg;
  assign re    = re_reg;
  assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_sram_seq.sv
// Directed bench: a burst instance and a single-word instance share SCK/mosi/rst_n.
module tb_spi_sram_seq;

  logic SCK = 1'b0;
  logic rst_n = 1'b1;
  logic ss_b = 1'b1;
  logic ss_s = 1'b1;
  logic mosi = 1'b0;

  logic       miso_b, we_b, re_b, busy_b;
  logic [7:0] addr_b, wdata_b;
  logic [7:0] rdata_b = 8'h00;
  logic       miso_s, we_s, re_s, busy_s;
  logic [7:0] addr_s, wdata_s;
  logic [7:0] rdata_s = 8'h00;

  logic [7:0]  mem [256];
  logic [15:0] we_log_b [$];
  logic [15:0] we_log_s [$];
  int re_cnt_b = 0;
  int overlap = 0;
  int errors = 0;
  int checks = 0;

  always #5 SCK = ~SCK;

  spi_sram_seq #(.ADDR_W(8), .DATA_W(8), .BURST_EN(1)) dut_b (
    .SCK(SCK), .rst_n(rst_n), .ss(ss_b), .mosi(mosi), .miso(miso_b),
    .addr(addr_b), .wdata(wdata_b), .we(we_b), .re(re_b), .rdata(rdata_b), .busy(busy_b)
  );

  spi_sram_seq #(.ADDR_W(8), .DATA_W(8), .BURST_EN(0)) dut_s (
    .SCK(SCK), .rst_n(rst_n), .ss(ss_s), .mosi(mosi), .miso(miso_s),
    .addr(addr_s), .wdata(wdata_s), .we(we_s), .re(re_s), .rdata(rdata_s), .busy(busy_s)
  );

  // Synchronous SRAM model plus strobe logging.
  always @(posedge SCK) begin
    if (re_b) rdata_b <= mem[addr_b];
    if (re_b) re_cnt_b <= re_cnt_b + 1;
    if (we_b) we_log_b.push_back({addr_b, wdata_b});
    if (we_s) we_log_s.push_back({addr_s, wdata_s});
    if ((we_b && re_b) || (we_s && re_s)) overlap <= overlap + 1;
  end

  task automatic tick(input logic b);
    mosi = b;
    @(posedge SCK);
    @(negedge SCK);
  endtask

  task automatic send(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) tick(v[i]);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge SCK);
    checks++;
    if ({miso_b, we_b, re_b, busy_b, addr_b, wdata_b} !== 20'h0) begin
      errors++; $display("FAIL reset_b: got %h want 00000", {miso_b, we_b, re_b, busy_b, addr_b, wdata_b});
    end
    checks++;
    if ({miso_s, we_s, re_s, busy_s, addr_s, wdata_s} !== 20'h0) begin
      errors++; $display("FAIL reset_s: got %h want 00000", {miso_s, we_s, re_s, busy_s, addr_s, wdata_s});
    end
    rst_n = 1'b1;
    tick(1'b0);
    tick(1'b0);
    checks++;
    if (busy_b !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy=%b want 0", busy_b);
    end
    $display("reset: done");
  endtask

  task automatic test_single_write;
    ss_s = 1'b0;
    tick(1'b0);
    checks++;
    if (busy_s !== 1'b1) begin
      errors++; $display("FAIL single_select: busy=%b want 1", busy_s);
    end
    send(8'h02);
    send(8'h10);
    send(8'hA5);
    checks++;
    if ({we_s, addr_s, wdata_s} !== {1'b1, 8'h10, 8'hA5}) begin
      errors++; $display("FAIL single_we: we/addr/wdata=%b/%h/%h want 1/10/a5", we_s, addr_s, wdata_s);
    end
    tick(1'b1);
    checks++;
    if ({we_s, busy_s} !== 2'b01) begin
      errors++; $display("FAIL single_ignore: we=%b busy=%b want 0 1", we_s, busy_s);
    end
    send(8'hFF);
    checks++;
    if (we_log_s.size() !== 1 || we_log_s[0] !== 16'h10A5) begin
      errors++; $display("FAIL single_log: count=%0d first=%h want 1 10a5", we_log_s.size(), we_log_s[0]);
    end
    checks++;
    if (miso_s !== 1'b0) begin
      errors++; $display("FAIL single_miso: miso=%b want 0", miso_s);
    end
    ss_s = 1'b1;
    tick(1'b0);
    checks++;
    if (busy_s !== 1'b0) begin
      errors++; $display("FAIL single_release: busy=%b want 0", busy_s);
    end
    $display("single write: addr=10 data=a5 pulses=%0d", we_log_s.size());
  endtask

  task automatic test_burst_read_wrap;
    logic [15:0] word;
    word = 16'h0;
    mem[8'hFF] = 8'h3C;
    mem[8'h00] = 8'hC3;
    mem[8'h01] = 8'h00;
    ss_b = 1'b0;
    tick(1'b0);
    send(8'h03);
    send(8'hFF);
    checks++;
    if ({re_b, addr_b} !== {1'b1, 8'hFF}) begin
      errors++; $display("FAIL read_first_re: re/addr=%b/%h want 1/ff", re_b, addr_b);
    end
    tick(1'b0);
    tick(1'b0);
    for (int i = 0; i < 16; i++) begin
      word = {word[14:0], miso_b};
      if (i == 6) begin
        checks++;
        if ({re_b, addr_b} !== {1'b1, 8'h00}) begin
          errors++; $display("FAIL read_prefetch_wrap: re/addr=%b/%h want 1/00", re_b, addr_b);
        end
      end
      tick(1'b0);
    end
    checks++;
    if (word !== 16'h3CC3) begin
      errors++; $display("FAIL read_stream: got %h want 3cc3", word);
    end
    ss_b = 1'b1;
    tick(1'b0);
    checks++;
    if ({busy_b, miso_b} !== 2'b00) begin
      errors++; $display("FAIL read_release: busy=%b miso=%b want 0 0", busy_b, miso_b);
    end
    $display("burst read: stream=%h", word);
  endtask

  task automatic test_burst_write;
    int n0;
    n0 = we_log_b.size();
    ss_b = 1'b0;
    tick(1'b0);
    send(8'h02);
    send(8'h20);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    checks++;
    if ({we_b, addr_b, wdata_b} !== {1'b1, 8'h22, 8'h33}) begin
      errors++; $display("FAIL bwrite_last: we/addr/wdata=%b/%h/%h want 1/22/33", we_b, addr_b, wdata_b);
    end
    ss_b = 1'b1;
    tick(1'b0);
    checks++;
    if (we_log_b.size() !== n0 + 3) begin
      errors++; $display("FAIL bwrite_count: got %0d want %0d", we_log_b.size() - n0, 3);
    end
    checks++;
    if (we_log_b[n0] !== 16'h2011) begin
      errors++; $display("FAIL bwrite_w0: got %h want 2011", we_log_b[n0]);
    end
    checks++;
    if (we_log_b[n0+1] !== 16'h2122) begin
      errors++; $display("FAIL bwrite_w1: got %h want 2122", we_log_b[n0+1]);
    end
    checks++;
    if (we_log_b[n0+2] !== 16'h2233) begin
      errors++; $display("FAIL bwrite_w2: got %h want 2233", we_log_b[n0+2]);
    end
    $display("burst write: pulses=%0d", we_log_b.size() - n0);
  endtask

  task automatic test_aborted_write;
    int n0;
    n0 = we_log_b.size();
    ss_b = 1'b0;
    tick(1'b0);
    send(8'h02);
    send(8'h40);
    for (int i = 0; i < 5; i++) tick(1'b1);
    ss_b = 1'b1;
    tick(1'b1);
    checks++;
    if (busy_b !== 1'b0) begin
      errors++; $display("FAIL abort_idle: busy=%b want 0", busy_b);
    end
    tick(1'b1);
    tick(1'b1);
    checks++;
    if (we_log_b.size() !== n0) begin
      errors++; $display("FAIL abort_no_we: pulses=%0d want 0", we_log_b.size() - n0);
    end
    $display("aborted write: pulses=%0d", we_log_b.size() - n0);
  endtask

  task automatic test_unknown_opcode;
    int n_we;
    int n_re;
    int bad;
    n_we = we_log_b.size();
    n_re = re_cnt_b;
    bad = 0;
    ss_b = 1'b0;
    tick(1'b0);
    send(8'h9F);
    checks++;
    if (busy_b !== 1'b1) begin
      errors++; $display("FAIL unk_ignore: busy=%b want 1", busy_b);
    end
    for (int i = 0; i < 12; i++) begin
      tick(i[0]);
      if (miso_b !== 1'b0 || we_b !== 1'b0 || re_b !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL unk_quiet: active cycles=%0d want 0", bad);
    end
    checks++;
    if (re_cnt_b !== n_re || we_log_b.size() !== n_we) begin
      errors++; $display("FAIL unk_strobes: re=%0d we=%0d want 0 0", re_cnt_b - n_re, we_log_b.size() - n_we);
    end
    ss_b = 1'b1;
    tick(1'b0);
    checks++;
    if (busy_b !== 1'b0) begin
      errors++; $display("FAIL unk_release: busy=%b want 0", busy_b);
    end
    $display("unknown opcode 9f: ignored");
  endtask

  task automatic test_reset_mid_read;
    logic [7:0] byte_rx;
    byte_rx = 8'h00;
    mem[8'h05] = 8'hFF;
    mem[8'h07] = 8'h5A;
    ss_b = 1'b0;
    tick(1'b0);
    send(8'h03);
    send(8'h05);
    for (int i = 0; i < 5; i++) tick(1'b0);
    checks++;
    if ({busy_b, miso_b} !== 2'b11) begin
      errors++; $display("FAIL midread_active: busy=%b miso=%b want 1 1", busy_b, miso_b);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({miso_b, we_b, re_b, busy_b, addr_b, wdata_b} !== 20'h0) begin
      errors++; $display("FAIL midread_async: got %h want 00000", {miso_b, we_b, re_b, busy_b, addr_b, wdata_b});
    end
    ss_b = 1'b1;
    @(negedge SCK);
    rst_n = 1'b1;
    tick(1'b0);
    ss_b = 1'b0;
    tick(1'b0);
    send(8'h03);
    send(8'h07);
    checks++;
    if ({re_b, addr_b} !== {1'b1, 8'h07}) begin
      errors++; $display("FAIL postreset_re: re/addr=%b/%h want 1/07", re_b, addr_b);
    end
    tick(1'b0);
    tick(1'b0);
    for (int i = 0; i < 8; i++) begin
      byte_rx = {byte_rx[6:0], miso_b};
      tick(1'b0);
    end
    checks++;
    if (byte_rx !== 8'h5A) begin
      errors++; $display("FAIL postreset_data: got %h want 5a", byte_rx);
    end
    ss_b = 1'b1;
    tick(1'b0);
    $display("reset mid-read: post-reset byte=%h", byte_rx);
  endtask

  task automatic test_exclusive;
    checks++;
    if (overlap !== 0) begin
      errors++; $display("FAIL we_re_exclusive: overlap cycles=%0d want 0", overlap);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_single_write();
    test_burst_read_wrap();
    test_burst_write();
    test_aborted_write();
    test_unknown_opcode();
    test_reset_mid_read();
    test_exclusive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
